// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with load/ack divisor handshake.
// Optional one-cycle tick strobe at end of period when CLKDIV_TICK_EN is defined.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clkIN,
  input  logic             rstN,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic [WIDTH-1:0] div_cur,
  output logic             clkOUT
`ifdef CLKDIV_TICK_EN
  ,
  output logic             tick
`endif
);

  localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MinDiv = WIDTH'(2);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] divQ;
  logic [WIDTH-1:0] pendVal;
  logic             pendFlag;
  logic             ackQ;
  logic             clkQ;

  logic             wrap;
  logic             apply;
  logic [WIDTH-1:0] nCount;
  logic [WIDTH-1:0] nDiv;
  logic [WIDTH-1:0] nLo;
  logic [WIDTH-1:0] loadVal;
  logic             nClk;

  // Next count, divisor swap and registered clock level for the coming cycle
  always_comb begin
    wrap    = (count >= divQ - One);
    apply   = pendFlag && (!en || wrap);
    nDiv    = apply ? pendVal : divQ;
    loadVal = (div_in < MinDiv) ? MinDiv : div_in;
    nCount  = '0;
    if (en && !wrap) begin
      nCount = count + One;
    end
    nLo  = nDiv - (nDiv >> 1);
    nClk = en && (nCount >= nLo);
  end

  // Counter, divisor and output clock state
  always_ff @(posedge clkIN or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
      divQ  <= DefDiv;
      ackQ  <= 1'b0;
      clkQ  <= 1'b0;
    end else begin
      count <= nCount;
      divQ  <= nDiv;
      ackQ  <= apply;
      clkQ  <= nClk;
    end
  end

  // Pending divisor; a load on the apply edge is kept for the next apply
  always_ff @(posedge clkIN or negedge rstN) begin
    if (!rstN) begin
      pendVal  <= '0;
      pendFlag <= 1'b0;
    end else begin
      if (div_load) begin
        pendVal  <= loadVal;
        pendFlag <= 1'b1;
      end else if (apply) begin
        pendFlag <= 1'b0;
      end
    end
  end

  assign div_ack = ackQ;
  assign div_cur = divQ;
  assign clkOUT  = clkQ;

`ifdef CLKDIV_TICK_EN
  // Clock-enable strobe on the last count of each period
  always_comb begin
    tick = en && (count == divQ - One);
  end
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: per-cycle scoreboard from a behavioural model,
// plus fixed waveform windows and handshake counts.
module tb_clk_div_prog;

  logic        clkIN = 1'b0;
  logic        rstN;
  logic        en;
  logic        div_load;
  logic [7:0]  div_in;
  logic        div_ack;
  logic [7:0]  div_cur;
  logic        clkOUT;
  logic        en16;
  logic        ld16;
  logic [15:0] din16;
  logic        ack16;
  logic [15:0] cur16;
  logic        clk16;
`ifdef CLKDIV_TICK_EN
  logic        tick;
  logic        tick16;
`endif

  clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(10)) dut (
    .clkIN(clkIN), .rstN(rstN), .en(en),
    .div_in(div_in), .div_load(div_load),
    .div_ack(div_ack), .div_cur(div_cur),
    .clkOUT(clkOUT)
`ifdef CLKDIV_TICK_EN
    , .tick(tick)
`endif
  );

  clk_div_prog #(.WIDTH(16), .DEFAULT_DIV(1000)) dut16 (
    .clkIN(clkIN), .rstN(rstN), .en(en16),
    .div_in(din16), .div_load(ld16),
    .div_ack(ack16), .div_cur(cur16),
    .clkOUT(clk16)
`ifdef CLKDIV_TICK_EN
    , .tick(tick16)
`endif
  );

  always #5 clkIN = ~clkIN;

  typedef struct {
    logic       c;
    logic       a;
    logic [7:0] d;
    logic       t;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mCount;
  int   mN;
  int   mPV;
  bit   mPF;
  int   acks;
  int   ticks;
  int   k16;
  int   hi16;
  logic s1499;
  logic s1500;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mCount = 0;
    mN     = 10;
    mPF    = 1'b0;
    mPV    = 0;
  endtask

  task automatic cyc(input logic e, input logic ld, input int d);
    exp_t x;
    int   nc;
    en       = e;
    div_load = ld;
    div_in   = 8'(d);
    @(posedge clkIN);
    if (!e || mCount == mN - 1) nc = 0;
    else nc = mCount + 1;
    x.a = 1'b0;
    if (mPF && (!e || mCount == mN - 1)) begin
      mN  = mPV;
      mPF = 1'b0;
      x.a = 1'b1;
    end
    if (ld) begin
      mPV = (d < 2) ? 2 : d;
      mPF = 1'b1;
    end
    mCount = nc;
    x.c = e && (mCount >= mN - mN / 2);
    x.d = 8'(mN);
    x.t = e && (mCount == mN - 1);
    sb.push_back(x);
    @(negedge clkIN);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      x = sb.pop_front();
      chk("clkOUT", int'(clkOUT), int'(x.c));
      chk("div_ack", int'(div_ack), int'(x.a));
      chk("div_cur", int'(div_cur), int'(x.d));
`ifdef CLKDIV_TICK_EN
      chk("tick", int'(tick), int'(x.t));
      if (tick) ticks++;
`endif
    end
    if (div_ack) acks++;
    k16++;
    if (k16 >= 1000 && k16 < 2000 && clk16) hi16++;
    if (k16 == 1499) s1499 = clk16;
    if (k16 == 1500) s1500 = clk16;
  endtask

  task automatic alignEnd();
    for (int i = 0; i < 300; i++) begin
      if (mCount == mN - 1) return;
      cyc(1'b1, 1'b0, 0);
    end
    chk("align_timeout", 0, 1);
  endtask

  task automatic grab(input int n, output logic [15:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 0);
      v[i] = clkOUT;
    end
  endtask

  logic [15:0] v;

  initial begin
    rstN = 1'b0; en = 1'b0; div_load = 1'b0; div_in = '0;
    en16 = 1'b1; ld16 = 1'b0; din16 = '0;
    acks = 0; ticks = 0; k16 = 0; hi16 = 0;
    s1499 = 1'bx; s1500 = 1'bx;
    modelReset();
    @(negedge clkIN);
    chk("rst_clk", int'(clkOUT), 0);
    chk("rst_ack", int'(div_ack), 0);
    chk("rst_cur", int'(div_cur), 10);
    chk("rst_cur16", int'(cur16), 1000);
    @(negedge clkIN);
    rstN = 1'b1;

    // 1: default N=10, and 16-bit N=1000 alongside
    repeat (2000) cyc(1'b1, 1'b0, 0);
    chk("w16_high", hi16, 500);
    chk("w16_s1499", int'(s1499), 0);
    chk("w16_s1500", int'(s1500), 1);
    alignEnd();
    grab(10, v);
    chk("t1_wave", int'(v[9:0]), 'h3E0);
    chk("t1_cur", int'(div_cur), 10);

    // 2: load 5 mid-period
    acks = 0;
    repeat (3) cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 5);
    chk("t2_old", int'(div_cur), 10);
    alignEnd();
    cyc(1'b1, 1'b0, 0);
    alignEnd();
    grab(5, v);
    chk("t2_wave", int'(v[4:0]), 'h18);
    chk("t2_cur", int'(div_cur), 5);
    chk("t2_acks", acks, 1);

    // 3a: loads 7 then 9 before wrap
    alignEnd();
    cyc(1'b1, 1'b0, 0);
    acks = 0;
    cyc(1'b1, 1'b1, 7);
    cyc(1'b1, 1'b1, 9);
    alignEnd();
    cyc(1'b1, 1'b0, 0);
    alignEnd();
    chk("t3_cur9", int'(div_cur), 9);
    chk("t3_acks", acks, 1);

    // 3b: loads 0 then 1 clamp to 2
    cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 0);
    cyc(1'b1, 1'b1, 1);
    alignEnd();
    cyc(1'b1, 1'b0, 0);
    alignEnd();
    grab(4, v);
    chk("t3_wave2", int'(v[3:0]), 'hA);
    chk("t3_cur2", int'(div_cur), 2);

    // 4: load on the wrap edge waits for the next wrap
    alignEnd();
    acks = 0;
    cyc(1'b1, 1'b1, 6);
    chk("t4_hold", int'(div_cur), 2);
    chk("t4_noack", acks, 0);
    alignEnd();
    cyc(1'b1, 1'b0, 0);
    chk("t4_cur", int'(div_cur), 6);
    alignEnd();
    grab(6, v);
    chk("t4_wave", int'(v[5:0]), 'h38);

    // 5: disable applies pending, loads while disabled, fresh restart
    cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 4);
    acks = 0;
    cyc(1'b0, 1'b0, 0);
    chk("t5_off_clk", int'(clkOUT), 0);
    cyc(1'b0, 1'b0, 0);
    chk("t5_acks", acks, 1);
    chk("t5_cur4", int'(div_cur), 4);
    cyc(1'b0, 1'b1, 8);
    cyc(1'b0, 1'b0, 0);
    chk("t5_cur8", int'(div_cur), 8);
    grab(8, v);
    chk("t5_fresh", int'(v[7:0]), 'h78);

`ifdef CLKDIV_TICK_EN
    // 6: tick strobe with N=4
    alignEnd();
    cyc(1'b1, 1'b1, 4);
    alignEnd();
    cyc(1'b1, 1'b0, 0);
    alignEnd();
    ticks = 0;
    repeat (8) cyc(1'b1, 1'b0, 0);
    chk("t6_ticks", ticks, 2);
`endif

    // async reset in the high phase drops a pending load
    alignEnd();
    cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 3);
    alignEnd();
    chk("t5_high", int'(clkOUT), 1);
    #2 rstN = 1'b0;
    #1;
    chk("ar_clk", int'(clkOUT), 0);
    chk("ar_ack", int'(div_ack), 0);
    chk("ar_cur", int'(div_cur), 10);
    @(negedge clkIN);
    rstN = 1'b1;
    modelReset();
    acks = 0;
    repeat (25) cyc(1'b1, 1'b0, 0);
    chk("ar_lost", acks, 0);
    chk("ar_cur10", int'(div_cur), 10);
    chk("sb_left", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
